// File: rtl/pipe_chain.sv
// Configurable pipeline-register chain between decode and write-back.
// Per-stage hold/flush, youngest-first register forwarding, load-use hazard and event counters.
module pipe_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int ADDR_W = 5,
    parameter int LD_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    input  logic [WIDTH-1:0]  in_data_i,
    input  logic [ADDR_W-1:0] in_rd_i,
    input  logic              in_we_i,
    input  logic              in_ld_i,
    output logic              in_ready_o,
    input  logic [STAGES-1:0] hold_i,
    input  logic [STAGES-1:0] flush_i,
    output logic [STAGES-1:0] stage_valid_o,
    output logic              out_valid_o,
    output logic [WIDTH-1:0]  out_data_o,
    output logic [ADDR_W-1:0] out_rd_o,
    output logic              out_we_o,
    input  logic [ADDR_W-1:0] qa_i,
    input  logic [ADDR_W-1:0] qb_i,
    output logic              fwd_a_hit_o,
    output logic              fwd_b_hit_o,
    output logic [WIDTH-1:0]  fwd_a_o,
    output logic [WIDTH-1:0]  fwd_b_o,
    output logic              hazard_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_we;
    logic [STAGES-1:0] r_ld;
    logic [WIDTH-1:0]  r_data [STAGES];
    logic [ADDR_W-1:0] r_rd   [STAGES];
    logic [CNT_W-1:0]  r_bubble_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic [STAGES-1:0] w_eff_hold;
    logic [STAGES-1:0] w_up_hold;
    logic [STAGES-1:0] w_prev_valid;
    logic [STAGES-1:0] w_prev_we;
    logic [STAGES-1:0] w_prev_ld;
    logic [WIDTH-1:0]  w_prev_data [STAGES];
    logic [ADDR_W-1:0] w_prev_rd   [STAGES];

    logic [ADDR_W-1:0] w_q     [2];
    logic [WIDTH-1:0]  w_fdata [2];
    logic [1:0]        w_match;
    logic [1:0]        w_early;

    // A stall in any older stage freezes every younger one.
    always_comb begin
        w_eff_hold = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_eff_hold[k] = |(hold_i >> k);
        end
    end

    assign w_up_hold    = {w_eff_hold[STAGES-2:0], 1'b0};
    assign w_prev_valid = {r_valid[STAGES-2:0], in_valid_i};
    assign w_prev_we    = {r_we[STAGES-2:0], in_we_i};
    assign w_prev_ld    = {r_ld[STAGES-2:0], in_ld_i};

    always_comb begin
        w_prev_data[0] = in_data_i;
        w_prev_rd[0]   = in_rd_i;
        for (int k = 1; k < STAGES; k++) begin
            w_prev_data[k] = r_data[k-1];
            w_prev_rd[k]   = r_rd[k-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_we    <= '0;
            r_ld    <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_data[k] <= '0;
                r_rd[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush_i[k]) begin
                    r_valid[k] <= 1'b0;
                end else if (w_eff_hold[k]) begin
                    r_valid[k] <= r_valid[k];
                end else if (w_up_hold[k]) begin
                    r_valid[k] <= 1'b0;
                end else begin
                    r_valid[k] <= w_prev_valid[k];
                    r_we[k]    <= w_prev_we[k];
                    r_ld[k]    <= w_prev_ld[k];
                    r_data[k]  <= w_prev_data[k];
                    r_rd[k]    <= w_prev_rd[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (!r_valid[STAGES-1] && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            if ((|flush_i) && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign w_q[0] = qa_i;
    assign w_q[1] = qb_i;

    // Scan oldest to youngest so the youngest match is the one that sticks.
    always_comb begin
        w_match = '0;
        w_early = '0;
        for (int p = 0; p < 2; p++) begin
            w_fdata[p] = '0;
            for (int k = STAGES-1; k >= 0; k--) begin
                if (r_valid[k] && r_we[k] && (r_rd[k] == w_q[p])) begin
                    w_match[p] = 1'b1;
                    w_fdata[p] = r_data[k];
                    w_early[p] = r_ld[k] && (k < LD_LAT);
                end
            end
            if (w_q[p] == '0) begin
                w_match[p] = 1'b0;
                w_early[p] = 1'b0;
                w_fdata[p] = '0;
            end
        end
    end

    assign hazard_o    = |(w_match & w_early);
    assign fwd_a_hit_o = w_match[0] & ~w_early[0];
    assign fwd_b_hit_o = w_match[1] & ~w_early[1];
    assign fwd_a_o     = fwd_a_hit_o ? w_fdata[0] : '0;
    assign fwd_b_o     = fwd_b_hit_o ? w_fdata[1] : '0;

    assign in_ready_o    = ~w_eff_hold[0];
    assign stage_valid_o = r_valid;
    assign out_valid_o   = r_valid[STAGES-1];
    assign out_data_o    = r_data[STAGES-1];
    assign out_rd_o      = r_rd[STAGES-1];
    assign out_we_o      = r_we[STAGES-1];
    assign bubble_cnt_o  = r_bubble_cnt;
    assign flush_cnt_o   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain: scoreboard on the write-back port plus directed
// checks of hold, flush, forwarding, load-use, reset and counter saturation.
module tb_pipe_chain;
    localparam int W  = 32;
    localparam int S  = 4;
    localparam int A  = 5;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i, in_valid_i, in_we_i, in_ld_i, in_ready_o;
    logic [W-1:0]  in_data_i, out_data_o, fwd_a_o, fwd_b_o;
    logic [A-1:0]  in_rd_i, out_rd_o, qa_i, qb_i;
    logic [S-1:0]  hold_i, flush_i, stage_valid_o;
    logic          out_valid_o, out_we_o, fwd_a_hit_o, fwd_b_hit_o, hazard_o;
    logic [15:0]   bubble_cnt_o, flush_cnt_o;

    logic          c_rst, c_ready, c_ovalid, c_owe, c_ahit, c_bhit, c_haz;
    logic [S-1:0]  c_svalid;
    logic [W-1:0]  c_odata, c_fa, c_fb;
    logic [A-1:0]  c_ord;
    logic [CW-1:0] c_bubble, c_flush;

    pipe_chain dut (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
        .in_rd_i(in_rd_i), .in_we_i(in_we_i), .in_ld_i(in_ld_i), .in_ready_o(in_ready_o),
        .hold_i(hold_i), .flush_i(flush_i), .stage_valid_o(stage_valid_o),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_rd_o(out_rd_o),
        .out_we_o(out_we_o), .qa_i(qa_i), .qb_i(qb_i), .fwd_a_hit_o(fwd_a_hit_o),
        .fwd_b_hit_o(fwd_b_hit_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
        .hazard_o(hazard_o), .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    pipe_chain #(.CNT_W(CW)) dut_c (
        .clk_i(clk), .rst_i(c_rst), .in_valid_i(1'b0), .in_data_i('0),
        .in_rd_i('0), .in_we_i(1'b0), .in_ld_i(1'b0), .in_ready_o(c_ready),
        .hold_i('0), .flush_i('0), .stage_valid_o(c_svalid),
        .out_valid_o(c_ovalid), .out_data_o(c_odata), .out_rd_o(c_ord),
        .out_we_o(c_owe), .qa_i('0), .qb_i('0), .fwd_a_hit_o(c_ahit),
        .fwd_b_hit_o(c_bhit), .fwd_a_o(c_fa), .fwd_b_o(c_fb),
        .hazard_o(c_haz), .bubble_cnt_o(c_bubble), .flush_cnt_o(c_flush)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard entry: {we, rd, data}
    logic [W+A:0] sb_q[$];
    logic [W+A:0] sb_e;
    bit           sb_en = 1'b0;

    always @(negedge clk) begin
        if (sb_en && !rst_i) begin
            if (out_valid_o && !hold_i[S-1] && !flush_i[S-1]) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected_out", {32'd0, out_data_o}, 64'hDEAD);
                end else begin
                    sb_e = sb_q.pop_front();
                    check_eq("sb_data", 64'(out_data_o), 64'(sb_e[W-1:0]));
                    check_eq("sb_rd", 64'(out_rd_o), 64'(sb_e[W+A-1:W]));
                    check_eq("sb_we", 64'(out_we_o), 64'(sb_e[W+A]));
                end
            end
            if (in_valid_i && in_ready_o && !flush_i[0])
                sb_q.push_back({in_we_i, in_rd_i, in_data_i});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; in_valid_i = 1'b0; hold_i = '0; flush_i = '0;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic feed(input logic [W-1:0] d, input logic [A-1:0] rd, input logic ld);
        in_valid_i = 1'b1; in_data_i = d; in_rd_i = rd; in_we_i = 1'b1; in_ld_i = ld;
        tick();
        in_valid_i = 1'b0;
    endtask

    initial begin
        int idx;
        rst_i = 1'b1; c_rst = 1'b1;
        in_valid_i = 1'b0; in_data_i = '0; in_rd_i = '0; in_we_i = 1'b0; in_ld_i = 1'b0;
        hold_i = 4'b0100; flush_i = '0; qa_i = '0; qb_i = '0;
        tick(); tick();
        check_eq("rst_valid", 64'(stage_valid_o), 64'h0);
        check_eq("rst_out_data", 64'(out_data_o), 64'h0);
        check_eq("rst_bubble", 64'(bubble_cnt_o), 64'h0);
        check_eq("rst_flush", 64'(flush_cnt_o), 64'h0);
        check_eq("rst_ready_follows_hold", 64'(in_ready_o), 64'h0);
        hold_i = '0;
        c_rst  = 1'b0;

        // Stream of four back-to-back entries
        rst_i = 1'b0;
        sb_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid_i = (c < 4);
            in_data_i  = 32'h11 + 32'(c);
            in_rd_i    = A'(c + 1);
            in_we_i    = 1'b1;
            in_ld_i    = 1'b0;
            @(negedge clk);
            if (c == 3) check_eq("stream_latency_not_yet", 64'(out_valid_o), 64'h0);
            if (c == 4) check_eq("stream_first_out", 64'(out_data_o), 64'h11);
            if (c == 7) check_eq("stream_bubble_stop", 64'(bubble_cnt_o), 64'h4);
            tick();
        end
        check_eq("stream_drain", 64'(sb_q.size()), 64'h0);

        // Hold on stage 1 for two cycles mid-stream
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            hold_i     = (c == 3 || c == 4) ? 4'b0010 : 4'b0000;
            in_valid_i = (idx < 8);
            in_data_i  = 32'h21 + 32'(idx);
            in_rd_i    = A'(idx + 1);
            in_we_i    = 1'b1;
            @(negedge clk);
            if (c == 3 || c == 4) check_eq("hold_ready_low", 64'(in_ready_o), 64'h0);
            if (c == 5) begin
                check_eq("hold_stage2_bubble", 64'(stage_valid_o[2]), 64'h0);
                check_eq("hold_stage1_kept", 64'(stage_valid_o[1]), 64'h1);
            end
            if (in_valid_i && in_ready_o) idx++;
            tick();
        end
        in_valid_i = 1'b0;
        hold_i     = '0;
        check_eq("hold_all_sent", 64'(idx), 64'd8);
        check_eq("hold_drain", 64'(sb_q.size()), 64'h0);
        sb_en = 1'b0;

        // Flush of the two youngest stages
        do_reset();
        for (int i = 0; i < 4; i++) feed(32'h31 + 32'(i), A'(i + 1), 1'b0);
        check_eq("flush_pre_valid", 64'(stage_valid_o), 64'hF);
        flush_i = 4'b0011;
        tick();
        flush_i = '0;
        check_eq("flush_valid", 64'(stage_valid_o), 64'hC);
        check_eq("flush_cnt", 64'(flush_cnt_o), 64'h1);

        // Forwarding priority: stage3 rd5=BB, stage2 rd9=CC, stage1 rd5=AA, stage0 rd0
        do_reset();
        feed(32'hBB, 5'd5, 1'b0);
        feed(32'hCC, 5'd9, 1'b0);
        feed(32'hAA, 5'd5, 1'b0);
        feed(32'h0D, 5'd0, 1'b0);
        hold_i = 4'b1000;
        qa_i = 5'd5; qb_i = 5'd5; #1;
        check_eq("fwd_a_hit_young", 64'(fwd_a_hit_o), 64'h1);
        check_eq("fwd_a_young_val", 64'(fwd_a_o), 64'hAA);
        check_eq("fwd_b_young_val", 64'(fwd_b_o), 64'hAA);
        qa_i = 5'd9; #1;
        check_eq("fwd_a_mid_val", 64'(fwd_a_o), 64'hCC);
        qa_i = 5'd0; #1;
        check_eq("fwd_a_zero_nohit", 64'(fwd_a_hit_o), 64'h0);
        qa_i = 5'd3; #1;
        check_eq("fwd_a_miss_hit", 64'(fwd_a_hit_o), 64'h0);
        check_eq("fwd_a_miss_val", 64'(fwd_a_o), 64'h0);
        hold_i = 4'b1111;
        tick(); tick();
        check_eq("freeze_valid", 64'(stage_valid_o), 64'hF);
        check_eq("freeze_out", 64'(out_data_o), 64'hBB);

        // Reset while frozen and full
        rst_i = 1'b1;
        tick();
        check_eq("rst_mid_valid", 64'(stage_valid_o), 64'h0);
        check_eq("rst_mid_bubble", 64'(bubble_cnt_o), 64'h0);
        check_eq("rst_mid_flush", 64'(flush_cnt_o), 64'h0);
        rst_i = 1'b0; hold_i = '0; qa_i = '0; qb_i = '0;

        // Load-use hazard
        feed(32'h77, 5'd7, 1'b1);
        qb_i = 5'd7; #1;
        check_eq("lu_s0_hazard", 64'(hazard_o), 64'h1);
        check_eq("lu_s0_hit", 64'(fwd_b_hit_o), 64'h0);
        tick();
        check_eq("lu_s1_hazard", 64'(hazard_o), 64'h1);
        tick();
        check_eq("lu_s2_hazard", 64'(hazard_o), 64'h0);
        check_eq("lu_s2_hit", 64'(fwd_b_hit_o), 64'h1);
        check_eq("lu_s2_val", 64'(fwd_b_o), 64'h77);

        // Narrow counter instance has been idle well over 20 cycles
        check_eq("sat_bubble", 64'(c_bubble), 64'hF);
        check_eq("sat_flush_idle", 64'(c_flush), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
